// File: rtl/mc_core.sv
// mc_core: multicycle MIPS-subset core with a ready-handshaked unified memory port.
// Optional interrupt entry/return path (EPC, ie, eret) is built when MC_CORE_IRQ_EN is defined.
`timescale 1ns/1ps
module mc_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0080,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic              irq,
  output logic              irq_ack,
  output logic [31:0]       pc_o,
  output logic [31:0]       epc_o,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_ADDIEX = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ERET   = 4'd12,
    S_IRQ    = 4'd13,
    S_NOP    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_ERET = 6'h18;

  state_t      state;
  logic        started;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic [31:0] alu_out;
  logic [31:0] regs [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic signed [31:0] simm;
  logic [31:0] jtarget;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        irq_take;
  state_t      next_fetch;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign simm    = {{16{ir[15]}}, ir[15:0]};
  // pc already holds PC+4 once the instruction register is loaded
  assign jtarget = {pc[31:28], ir[25:0], 2'b00};
  assign rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];

  function automatic logic [31:0] alu_op(input logic [5:0] fn,
                                         input logic signed [31:0] x,
                                         input logic signed [31:0] y);
    logic [31:0] r;
    case (fn)
      FN_ADD:  r = x + y;
      FN_SUB:  r = x - y;
      FN_AND:  r = x & y;
      FN_OR:   r = x | y;
      FN_SLT:  r = (x < y) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic rtype_known(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic state_t dispatch(input logic [5:0] opc, input logic [5:0] fn);
    state_t s;
    case (opc)
      OP_RTYPE: s = rtype_known(fn) ? S_EXEC : S_NOP;
      OP_LW,
      OP_SW:    s = S_MEMADR;
      OP_BEQ:   s = S_BRANCH;
      OP_ADDI:  s = S_ADDIEX;
      OP_J:     s = S_JUMP;
`ifdef MC_CORE_IRQ_EN
      OP_COP0:  s = (fn == FN_ERET) ? S_ERET : S_NOP;
`endif
      default:  s = S_NOP;
    endcase
    return s;
  endfunction

`ifdef MC_CORE_IRQ_EN
  logic [31:0] epc;
  logic        ie;
  assign irq_take = irq && ie;
  assign irq_ack  = (state == S_IRQ);
  assign epc_o    = epc;
`else
  logic unused_irq;
  localparam logic [31:0] UNUSED_VECTOR = IRQ_VECTOR;
  localparam logic [5:0]  UNUSED_COP0   = OP_COP0;
  localparam logic [5:0]  UNUSED_ERET   = FN_ERET;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
  assign irq_ack    = 1'b0;
  assign epc_o      = 32'd0;
`endif

  // every path back to FETCH passes through the interrupt check
  assign next_fetch = irq_take ? S_IRQ : S_FETCH;

  // memory port decoded purely from registered state; started gates the cycle right after reset
  assign mem_req   = started && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
  assign mem_we    = (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc[ADDR_W-1:0] : alu_out[ADDR_W-1:0];
  assign mem_wdata = b;
  assign pc_o      = pc;
  assign state_o   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      started <= 1'b0;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a       <= 32'sd0;
      b       <= 32'sd0;
      alu_out <= 32'd0;
`ifdef MC_CORE_IRQ_EN
      epc     <= 32'd0;
      ie      <= 1'b1;
`endif
    end else begin
      started <= 1'b1;
      case (state)
        S_FETCH: begin
          if (!started) begin
            state <= next_fetch;
          end else if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {simm[29:0], 2'b00};
          state   <= dispatch(op, funct);
        end
        S_MEMADR: begin
          alu_out <= a + simm;
          state   <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mdr   <= mem_rdata;
            state <= S_MEMWB;
          end
        end
        S_MEMWB:  state <= next_fetch;
        S_MEMWR: begin
          if (mem_ready) state <= next_fetch;
        end
        S_EXEC: begin
          alu_out <= alu_op(funct, a, b);
          state   <= S_RWB;
        end
        S_RWB:    state <= next_fetch;
        S_ADDIEX: begin
          alu_out <= a + simm;
          state   <= S_IWB;
        end
        S_IWB:    state <= next_fetch;
        S_BRANCH: begin
          if (a == b) pc <= alu_out;
          state <= next_fetch;
        end
        S_JUMP: begin
          pc    <= jtarget;
          state <= next_fetch;
        end
`ifdef MC_CORE_IRQ_EN
        S_ERET: begin
          pc    <= epc;
          ie    <= 1'b1;
          state <= next_fetch;
        end
        // ie is still 1 during this cycle, so go straight to FETCH without re-checking
        S_IRQ: begin
          epc   <= pc;
          pc    <= IRQ_VECTOR;
          ie    <= 1'b0;
          state <= S_FETCH;
        end
`endif
        S_NOP:    state <= next_fetch;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // register file: write-back stages only; reset parks the FSM in FETCH so no write survives it
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = alu_out;
    case (state)
      S_MEMWB: begin wr_en = 1'b1; wr_addr = rt; wr_data = mdr;     end
      S_RWB:   begin wr_en = 1'b1; wr_addr = rd; wr_data = alu_out; end
      S_IWB:   begin wr_en = 1'b1; wr_addr = rt; wr_data = alu_out; end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: program execution, CPI, wait states, interrupts and reset abort.
`timescale 1ns/1ps
module tb_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, irq, irq_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o, epc_o;
  logic [3:0]  state_o;

  logic [31:0] img [1024];
  logic [31:0] mem [1024];
  logic [31:0] stall_addr;
  int          stall_load;
  int          stall_cnt;
  int          wr_cnt, ack_cnt, cyc;
  logic [31:0] fa[$];
  int          fc[$];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mc_core #(.RESET_PC(32'h0000_0100), .IRQ_VECTOR(32'h0000_0080), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .irq(irq),
    .irq_ack(irq_ack), .pc_o(pc_o), .epc_o(epc_o), .state_o(state_o)
  );

  assign mem_ready = mem_req && !(stall_cnt > 0 && mem_addr == stall_addr);
  assign mem_rdata = mem_ready ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
      stall_cnt <= stall_load;
      wr_cnt <= 0;
      ack_cnt <= 0;
      fa.delete();
      fc.delete();
    end else begin
      if (mem_req && mem_addr == stall_addr && stall_cnt > 0) stall_cnt <= stall_cnt - 1;
      if (mem_req && mem_we && mem_ready) begin
        mem[mem_addr[11:2]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (mem_req && !mem_we && mem_ready && state_o == 4'd0) begin
        fa.push_back(mem_addr);
        fc.push_back(cyc);
      end
      if (irq_ack) ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 32'd0;
  endtask

  task automatic start_phase();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_fetch(input int n, input int budget);
    int k = 0;
    while (fa.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("fetch_count_%0d", n), fa.size(), n);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int k = 0;
    while (state_o !== s && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, {28'd0, state_o}, {28'd0, s});
  endtask

  logic [31:0] exp_a [14];
  int          exp_d [13];

  initial begin
    irq = 1'b0;
    cyc = 0;
    stall_addr = 32'hFFFF_FFF0;
    stall_load = 0;

    // Program 1: arithmetic, memory, $0 write, NOP, branches, jump
    clear_img();
    img[32'h100 >> 2] = 32'h2001_0005; // addi $1,$0,5
    img[32'h104 >> 2] = 32'h2002_FFFD; // addi $2,$0,-3
    img[32'h108 >> 2] = 32'h0022_1820; // add  $3,$1,$2
    img[32'h10C >> 2] = 32'h0041_202A; // slt  $4,$2,$1
    img[32'h110 >> 2] = 32'hAC03_0040; // sw   $3,0x40($0)
    img[32'h114 >> 2] = 32'h8C05_0040; // lw   $5,0x40($0)
    img[32'h118 >> 2] = 32'h0021_0020; // add  $0,$1,$1
    img[32'h11C >> 2] = 32'h0001_5020; // add  $10,$0,$1
    img[32'h120 >> 2] = 32'hFC21_0800; // undefined op 0x3F
    img[32'h124 >> 2] = 32'h1022_0005; // beq  $1,$2,+5 (not taken)
    img[32'h128 >> 2] = 32'h0800_0080; // j    0x200
    img[32'h200 >> 2] = 32'h1000_FFFF; // beq  $0,$0,-1
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_pc", pc_o, 32'h100);
    check("rst_epc", epc_o, 32'd0);
    check("rst_state", {28'd0, state_o}, 32'd0);
    check("rst_irq_ack", {31'd0, irq_ack}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h100);
    @(posedge clk); #1;
    check("pc_after_ir", pc_o, 32'h104);

    exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
              32'h11C, 32'h120, 32'h124, 32'h128, 32'h200, 32'h200, 32'h200};
    exp_d = '{4, 4, 4, 4, 4, 5, 4, 4, 3, 3, 3, 3, 3};
    wait_fetch(14, 200);
    for (int i = 0; i < 14; i++) check($sformatf("p1_addr[%0d]", i), fa[i], exp_a[i]);
    for (int i = 0; i < 13; i++) check($sformatf("p1_cpi[%0d]", i), fc[i+1] - fc[i], exp_d[i]);
    check("r1", dut.regs[1], 32'd5);
    check("r2", dut.regs[2], 32'hFFFF_FFFD);
    check("r3_add", dut.regs[3], 32'd2);
    check("r4_slt", dut.regs[4], 32'd1);
    check("r5_lw", dut.regs[5], 32'd2);
    check("r10_zero_src", dut.regs[10], 32'd5);
    check("mem40", mem[16], 32'd2);
    check("p1_writes", wr_cnt, 32'd1);

    // Program 2: three wait states on a lw data read
    clear_img();
    img[32'h100 >> 2] = 32'h8C06_0044; // lw $6,0x44($0)
    img[32'h104 >> 2] = 32'h1000_FFFF; // beq $0,$0,-1
    img[32'h044 >> 2] = 32'h1234_5678;
    stall_addr = 32'h44;
    stall_load = 3;
    start_phase();
    wait_state(4'd3, 40, "p2_reach_memrd");
    for (int j = 0; j < 3; j++) begin
      check($sformatf("p2_stall_state[%0d]", j), {28'd0, state_o}, 32'd3);
      check($sformatf("p2_stall_addr[%0d]", j), mem_addr, 32'h44);
      check($sformatf("p2_stall_rdy[%0d]", j), {31'd0, mem_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("p2_ready", {31'd0, mem_ready}, 32'd1);
    wait_fetch(3, 60);
    check("p2_lw_cpi", fc[1] - fc[0], 32'd8);
    check("p2_next_addr", fa[1], 32'h104);
    check("p2_r6", dut.regs[6], 32'h1234_5678);

`ifdef MC_CORE_IRQ_EN
    // Program 3: interrupt raised during a lw, handler with irq held, eret and re-entry
    clear_img();
    img[32'h100 >> 2] = 32'h8C07_0048; // lw $7,0x48($0)
    img[32'h104 >> 2] = 32'h1000_FFFF; // beq $0,$0,-1
    img[32'h080 >> 2] = 32'h2008_0007; // addi $8,$0,7
    img[32'h084 >> 2] = 32'h4000_0018; // eret
    img[32'h048 >> 2] = 32'hCAFE_0001;
    stall_addr = 32'h48;
    stall_load = 2;
    start_phase();
    wait_state(4'd3, 40, "p3_reach_memrd");
    irq = 1'b1;
    wait_fetch(2, 60);
    check("p3_vec_addr", fa[1], 32'h80);
    check("p3_lw_irq_cpi", fc[1] - fc[0], 32'd8);
    check("p3_ack_once", ack_cnt, 32'd1);
    check("p3_epc", epc_o, 32'h104);
    check("p3_r7", dut.regs[7], 32'hCAFE_0001);
    wait_fetch(4, 60);
    check("p3_h1_addr", fa[2], 32'h84);
    check("p3_ret_addr", fa[3], 32'h104);
    check("p3_eret_cpi", fc[3] - fc[2], 32'd3);
    check("p3_no_nest", ack_cnt, 32'd1);
    wait_fetch(5, 60);
    check("p3_reenter_addr", fa[4], 32'h80);
    check("p3_reenter_cpi", fc[4] - fc[3], 32'd4);
    check("p3_ack_twice", ack_cnt, 32'd2);
    check("p3_r8", dut.regs[8], 32'd7);
    irq = 1'b0;
`else
    // Program 3: without the interrupt path, eret is a NOP and irq is ignored
    clear_img();
    img[32'h100 >> 2] = 32'h4000_0018; // eret (NOP here)
    img[32'h104 >> 2] = 32'h1000_FFFF; // beq $0,$0,-1
    stall_load = 0;
    irq = 1'b1;
    start_phase();
    wait_fetch(3, 60);
    check("p3_eret_nop_addr", fa[1], 32'h104);
    check("p3_eret_nop_cpi", fc[1] - fc[0], 32'd3);
    check("p3_loop_addr", fa[2], 32'h104);
    check("p3_no_ack", ack_cnt, 32'd0);
    check("p3_epc_zero", epc_o, 32'd0);
    irq = 1'b0;
`endif

    // Program 4: reset pulsed while a store is waiting for ready
    clear_img();
    img[32'h100 >> 2] = 32'h2009_0009; // addi $9,$0,9
    img[32'h104 >> 2] = 32'hAC09_004C; // sw $9,0x4C($0)
    stall_addr = 32'h4C;
    stall_load = 5;
    start_phase();
    wait_state(4'd5, 40, "p4_reach_memwr");
    check("p4_we", {31'd0, mem_we}, 32'd1);
    check("p4_addr", mem_addr, 32'h4C);
    check("p4_wdata", mem_wdata, 32'd9);
    img[32'h100 >> 2] = 32'h1000_FFFF;
    stall_load = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("p4_async_req", {31'd0, mem_req}, 32'd0);
    check("p4_async_pc", pc_o, 32'h100);
    check("p4_async_state", {28'd0, state_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_fetch(3, 60);
    check("p4_refetch", fa[0], 32'h100);
    check("p4_loop", fa[2], 32'h100);
    check("p4_no_write", wr_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
